// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcode map, FSM states, ALU encodings and step-count helpers
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_READ = 3'd1,
        EXECUTE    = 3'd2,
        HALT       = 3'd3,
        TRAP       = 3'd4
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_DEC = 2'b11;

    localparam logic [4:0] OP_NOP     = 5'h00;
    localparam logic [4:0] OP_MOV_A   = 5'h01;
    localparam logic [4:0] OP_MOV_B   = 5'h02;
    localparam logic [4:0] OP_LOAD_A  = 5'h03;
    localparam logic [4:0] OP_LOAD_B  = 5'h04;
    localparam logic [4:0] OP_STORE_A = 5'h05;
    localparam logic [4:0] OP_STORE_B = 5'h06;
    localparam logic [4:0] OP_ADD     = 5'h07;
    localparam logic [4:0] OP_SUB     = 5'h08;
    localparam logic [4:0] OP_OUT_A   = 5'h09;
    localparam logic [4:0] OP_OUT_B   = 5'h0A;
    localparam logic [4:0] OP_INC     = 5'h0B;
    localparam logic [4:0] OP_JZ      = 5'h0C;
    localparam logic [4:0] OP_DEC     = 5'h0D;
    localparam logic [4:0] OP_JMP     = 5'h0E;
    localparam logic [4:0] OP_JC      = 5'h0F;
    localparam logic [4:0] OP_HLT     = 5'h10;
    localparam logic [4:0] OP_JN      = 5'h11;
    localparam logic [4:0] OP_JNZ     = 5'h12;
    localparam logic [4:0] OP_JNC     = 5'h13;
    localparam logic [4:0] OP_UNDEF   = 5'h1F;

    function automatic logic is_defined(input logic [4:0] op);
        return op <= OP_JNC;
    endfunction

    // flags are {n, z, c}
    function automatic logic jump_taken(input logic [4:0] op, input logic [2:0] flags);
        logic t;
        case (op)
            OP_JZ:   t = flags[1];
            OP_JC:   t = flags[0];
            OP_JN:   t = flags[2];
            OP_JNZ:  t = !flags[1];
            OP_JNC:  t = !flags[0];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] op_steps(input logic [4:0] op, input logic taken);
        logic [1:0] n;
        case (op)
            OP_NOP, OP_HLT:                      n = 2'd1;
            OP_LOAD_A, OP_LOAD_B:                n = 2'd3;
            OP_JZ, OP_JC, OP_JN, OP_JNZ, OP_JNC: n = taken ? 2'd2 : 2'd1;
            default:                             n = is_defined(op) ? 2'd2 : 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// rtl/control_sequencer_decode.sv - combinational strobe and step decode; CONTROL_SEQUENCER_ILLEGAL_TRAP_EN selects trap on undefined opcodes
module control_sequencer_decode
    import control_sequencer_pkg::*;
#(
    parameter int STEP_W       = 2,
    parameter int OPCODE_WIDTH = 5
) (
    input  state_t                  state,
    input  logic [STEP_W-1:0]       step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              flags,
    input  logic                    cond_q,
    input  logic                    mem_ready,
    input  logic                    active,
    output logic                    mar_load,
    output logic                    mar_src_pc,
    output logic                    ram_read,
    output logic                    ram_write,
    output logic                    ir_load,
    output logic                    reg_load_a,
    output logic                    reg_enable_a,
    output logic                    reg_load_b,
    output logic                    reg_enable_b,
    output logic                    reg_load_o,
    output logic                    alu_enable,
    output logic [1:0]              alu_op,
    output logic                    out_bus,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic                    cond_now,
    output logic                    last_step,
    output logic                    step_hold,
    output logic                    halt_req,
    output logic                    trap_req
);

    logic [4:0] op;
    logic       s0, s1, s2;
    logic       cond_eff;

    // Any nonzero bit above bit 4 makes the opcode undefined.
    assign op = ((opcode >> 5) == '0) ? opcode[4:0] : OP_UNDEF;

    assign s0 = (step == '0);
    assign s1 = (step == STEP_W'(1));
    assign s2 = (step == STEP_W'(2));

    // Live flags decide step0; later steps use the value latched at step0.
    assign cond_now  = jump_taken(op, flags);
    assign cond_eff  = s0 ? cond_now : cond_q;
    assign last_step = ({{(8-STEP_W){1'b0}}, step} + 8'd1) == {6'd0, op_steps(op, cond_eff)};
    assign step_hold = (op == OP_LOAD_A || op == OP_LOAD_B) && s1 && !mem_ready;
    assign halt_req  = (op == OP_HLT) && s0;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    assign trap_req  = !is_defined(op) && s0;
`else
    assign trap_req  = 1'b0;
`endif

    always_comb begin
        mar_load     = 1'b0;
        mar_src_pc   = 1'b0;
        ram_read     = 1'b0;
        ram_write    = 1'b0;
        ir_load      = 1'b0;
        reg_load_a   = 1'b0;
        reg_enable_a = 1'b0;
        reg_load_b   = 1'b0;
        reg_enable_b = 1'b0;
        reg_load_o   = 1'b0;
        alu_enable   = 1'b0;
        alu_op       = ALU_ADD;
        out_bus      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        if (active) begin
            case (state)
                FETCH_ADDR: begin
                    mar_load   = 1'b1;
                    mar_src_pc = 1'b1;
                end
                FETCH_READ: begin
                    ram_read = 1'b1;
                    ir_load  = mem_ready;
                end
                EXECUTE: begin
                    case (op)
                        OP_NOP: pc_inc = s0;
                        OP_MOV_A: begin
                            out_bus    = s0;
                            reg_load_a = s0;
                            pc_inc     = s1;
                        end
                        OP_MOV_B: begin
                            out_bus    = s0;
                            reg_load_b = s0;
                            pc_inc     = s1;
                        end
                        OP_LOAD_A, OP_LOAD_B: begin
                            out_bus    = s0;
                            mar_load   = s0;
                            ram_read   = s1 || s2;
                            reg_load_a = s2 && (op == OP_LOAD_A);
                            reg_load_b = s2 && (op == OP_LOAD_B);
                            pc_inc     = s2;
                        end
                        OP_STORE_A, OP_STORE_B: begin
                            out_bus      = s0;
                            mar_load     = s0;
                            reg_enable_a = s1 && (op == OP_STORE_A);
                            reg_enable_b = s1 && (op == OP_STORE_B);
                            ram_write    = s1;
                            pc_inc       = s1;
                        end
                        OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                            alu_enable = s0;
                            reg_load_a = s0;
                            if (s0) begin
                                case (op)
                                    OP_SUB:  alu_op = ALU_SUB;
                                    OP_INC:  alu_op = ALU_INC;
                                    OP_DEC:  alu_op = ALU_DEC;
                                    default: alu_op = ALU_ADD;
                                endcase
                            end
                            pc_inc = s1;
                        end
                        OP_OUT_A: begin
                            reg_enable_a = s0;
                            reg_load_o   = s0;
                            pc_inc       = s1;
                        end
                        OP_OUT_B: begin
                            reg_enable_b = s0;
                            reg_load_o   = s0;
                            pc_inc       = s1;
                        end
                        OP_JMP: begin
                            out_bus = s0;
                            pc_load = s0;
                        end
                        OP_JZ, OP_JC, OP_JN, OP_JNZ, OP_JNC: begin
                            if (cond_eff) begin
                                out_bus = s0;
                                pc_load = s0;
                            end else begin
                                pc_inc = s0;
                            end
                        end
                        OP_HLT: ;
                        default: begin
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
                            pc_inc = 1'b0;
`else
                            pc_inc = s0;
`endif
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute control FSM; CONTROL_SEQUENCER_ILLEGAL_TRAP_EN enables the TRAP state
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MAX_STEPS    = 4,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    mem_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              flags,
    output logic                    mar_load,
    output logic                    mar_src_pc,
    output logic                    ram_read,
    output logic                    ram_write,
    output logic                    ir_load,
    output logic                    reg_load_a,
    output logic                    reg_enable_a,
    output logic                    reg_load_b,
    output logic                    reg_enable_b,
    output logic                    reg_load_o,
    output logic                    alu_enable,
    output logic [1:0]              alu_op,
    output logic                    out_bus,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic                    halted,
    output logic                    trap
);

    localparam int STEP_W = $clog2(MAX_STEPS);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic              cond_q;
    logic              cond_now, last_step, step_hold, halt_req, trap_req;

    control_sequencer_decode #(
        .STEP_W       (STEP_W),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decode (
        .state        (state),
        .step         (step),
        .opcode       (opcode),
        .flags        (flags),
        .cond_q       (cond_q),
        .mem_ready    (mem_ready),
        .active       (run && !reset),
        .mar_load     (mar_load),
        .mar_src_pc   (mar_src_pc),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ir_load      (ir_load),
        .reg_load_a   (reg_load_a),
        .reg_enable_a (reg_enable_a),
        .reg_load_b   (reg_load_b),
        .reg_enable_b (reg_enable_b),
        .reg_load_o   (reg_load_o),
        .alu_enable   (alu_enable),
        .alu_op       (alu_op),
        .out_bus      (out_bus),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .cond_now     (cond_now),
        .last_step    (last_step),
        .step_hold    (step_hold),
        .halt_req     (halt_req),
        .trap_req     (trap_req)
    );

    // HALT and TRAP fall through the default arm: only reset leaves them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH_ADDR;
            step   <= '0;
            cond_q <= 1'b0;
            halted <= 1'b0;
        end else if (run) begin
            case (state)
                FETCH_ADDR: state <= FETCH_READ;
                FETCH_READ: begin
                    if (mem_ready) begin
                        state <= EXECUTE;
                        step  <= '0;
                    end
                end
                EXECUTE: begin
                    if (step == '0) begin
                        cond_q <= cond_now;
                    end
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (trap_req) begin
                        state <= TRAP;
                    end else if (!step_hold) begin
                        if (last_step) begin
                            state <= FETCH_ADDR;
                            step  <= '0;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            trap <= 1'b0;
        end else if (run && state == EXECUTE && trap_req) begin
            trap <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
`endif

endmodule
